pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/fwd_match.sv | 52 +++++
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg                                                             |
// | Shared types and constants for the pipeline hazard controller.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package pipe_pkg;

    localparam int         REG_AW_DEF = 5;
    // Tracking entries carry rd at this fixed width so the struct can live here
    localparam int         REG_AW_MAX = 8;
    localparam logic [2:0] FWD_RF     = 3'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  wr;
        logic                  load;
    } trk_entry_t;

endpackage
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_match                                                            |
// | Finds the youngest in-flight producer of one source register and     |
// | reports whether the consumer in ID must stall on it.                 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module fwd_match
    import pipe_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LOAD_LAT = 2,
    parameter int FWD_EN   = 1
) (
    input  trk_entry_t [STAGES-2:0] i_table,
    input  logic [REG_AW-1:0]       i_src,
    input  logic                    i_use,
    output logic                    o_hit,
    output logic [2:0]              o_idx,
    output logic                    o_stall_need
);

    logic [STAGES-2:0] w_match;
    logic              w_load;
    logic              w_lat_short;

    for (genvar j = 0; j < STAGES-1; j++) begin : g_match
        assign w_match[j] = i_table[j].valid && i_table[j].wr && i_use &&
                            (i_src != '0) &&
                            (i_table[j].rd == REG_AW_MAX'(i_src));
    end

    // Scan oldest to youngest so the youngest producer wins
    always_comb begin
        o_hit  = 1'b0;
        o_idx  = 3'd0;
        w_load = 1'b0;
        for (int j = STAGES-2; j >= 0; j--) begin
            if (w_match[j]) begin
                o_hit  = 1'b1;
                o_idx  = 3'(j);
                w_load = i_table[j].load;
            end
        end
    end

    assign w_lat_short  = (int'(o_idx) + 1) < LOAD_LAT;
    assign o_stall_need = (FWD_EN != 0) ? (o_hit && w_load && w_lat_short) : o_hit;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl                                                     |
// | RAW hazard detection, load-use stall, forwarding select and branch   |
// | flush for an in-order pipeline with STAGES tracked stages after ID.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LOAD_LAT = 2,
    parameter int FWD_EN   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              redirect,
    output logic              stall,
    output logic              flush,
    output logic [2:0]        fwd_a,
    output logic [2:0]        fwd_b,
    output logic [15:0]       stall_cnt
);

    // The last stage retires into the register file on the same edge a
    // consumer leaves ID, so it never creates a hazard and is not stored.
    trk_entry_t [STAGES-2:0] r_table;
    trk_entry_t              w_new;
    logic [2:0]              r_fwd_a;
    logic [2:0]              r_fwd_b;
    logic [15:0]             r_stall_cnt;

    logic       w_hit_a;
    logic       w_hit_b;
    logic [2:0] w_idx_a;
    logic [2:0] w_idx_b;
    logic       w_need_a;
    logic       w_need_b;
    logic       w_issue;

    fwd_match #(
        .STAGES  (STAGES),
        .REG_AW  (REG_AW),
        .LOAD_LAT(LOAD_LAT),
        .FWD_EN  (FWD_EN)
    ) u_match_rs (
        .i_table     (r_table),
        .i_src       (id_rs),
        .i_use       (id_use_rs),
        .o_hit       (w_hit_a),
        .o_idx       (w_idx_a),
        .o_stall_need(w_need_a)
    );

    fwd_match #(
        .STAGES  (STAGES),
        .REG_AW  (REG_AW),
        .LOAD_LAT(LOAD_LAT),
        .FWD_EN  (FWD_EN)
    ) u_match_rt (
        .i_table     (r_table),
        .i_src       (id_rt),
        .i_use       (id_use_rt),
        .o_hit       (w_hit_b),
        .o_idx       (w_idx_b),
        .o_stall_need(w_need_b)
    );

    assign flush   = redirect;
    assign stall   = id_valid && !redirect && (w_need_a || w_need_b);
    assign w_issue = id_valid && !stall && !redirect;

    always_comb begin
        w_new       = '0;
        w_new.valid = w_issue;
        w_new.rd    = REG_AW_MAX'(id_rd);
        w_new.wr    = w_issue && id_wr;
        w_new.load  = w_issue && id_load;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_table     <= '0;
            r_fwd_a     <= FWD_RF;
            r_fwd_b     <= FWD_RF;
            r_stall_cnt <= 16'd0;
        end else begin
            r_table[0] <= w_new;
            for (int j = 1; j < STAGES-1; j++) begin
                r_table[j] <= r_table[j-1];
            end
            // Producer at j moves to j+1 on the same edge the consumer enters EX
            r_fwd_a <= (w_issue && (FWD_EN != 0) && w_hit_a) ? (w_idx_a + 3'd1) : FWD_RF;
            r_fwd_b <= (w_issue && (FWD_EN != 0) && w_hit_b) ? (w_idx_b + 3'd1) : FWD_RF;
            if (stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign fwd_a     = r_fwd_a;
    assign fwd_b     = r_fwd_b;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl                                                  |
// | Three configurations driven in parallel and compared against an      |
// | issue-log model of register producers.                               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

    localparam int NI = 3;
    localparam int HD = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_wr, id_load, redirect;
    logic [4:0] id_rs, id_rt, id_rd;

    logic        o_stall [NI];
    logic        o_flush [NI];
    logic [2:0]  o_fa    [NI];
    logic [2:0]  o_fb    [NI];
    logic [15:0] o_cnt   [NI];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pipe_hazard_ctrl #(
            .STAGES  (g == 0 ? 3 : (g == 1 ? 4 : 8)),
            .REG_AW  (5),
            .LOAD_LAT(2),
            .FWD_EN  (g == 0 ? 1 : 0)
        ) u_dut (
            .clock    (clock),
            .reset    (reset),
            .id_valid (id_valid),
            .id_rs    (id_rs),
            .id_rt    (id_rt),
            .id_use_rs(id_use_rs),
            .id_use_rt(id_use_rt),
            .id_rd    (id_rd),
            .id_wr    (id_wr),
            .id_load  (id_load),
            .redirect (redirect),
            .stall    (o_stall[g]),
            .flush    (o_flush[g]),
            .fwd_a    (o_fa[g]),
            .fwd_b    (o_fb[g]),
            .stall_cnt(o_cnt[g])
        );
    end

    function automatic int p_st(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 4 : 8);
    endfunction
    function automatic int p_fe(input int i);
        return (i == 0) ? 1 : 0;
    endfunction
    localparam int P_LL = 2;

    // Issue log per configuration; slot 0 is the most recent issue
    bit h_v   [NI][HD];
    int h_cyc [NI][HD];
    int h_rd  [NI][HD];
    bit h_wr  [NI][HD];
    bit h_ld  [NI][HD];
    int exp_fa [NI];
    int exp_fb [NI];
    int exp_cnt[NI];
    int cyc;
    int n_cmp;
    int n_bad;
    int stall_run;
    bit seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    function automatic void find_src(input int i, input int r, input bit used,
                                     output bit found, output int stage, output bit ld);
        found = 1'b0;
        stage = 0;
        ld    = 1'b0;
        if (used && r != 0) begin
            for (int k = HD-1; k >= 0; k--) begin
                if (h_v[i][k] && h_wr[i][k] && h_rd[i][k] == r &&
                    (cyc - h_cyc[i][k]) <= p_st(i) - 2) begin
                    found = 1'b1;
                    stage = cyc - h_cyc[i][k];
                    ld    = h_ld[i][k];
                end
            end
        end
    endfunction

    function automatic void model_eval(input int i, output bit st, output int fwa, output int fwb);
        bit fa_f, fb_f, la, lb;
        int sa, sb;
        find_src(i, int'(id_rs), id_use_rs, fa_f, sa, la);
        find_src(i, int'(id_rt), id_use_rt, fb_f, sb, lb);
        if (p_fe(i) != 0)
            st = (fa_f && la && (sa + 1 < P_LL)) || (fb_f && lb && (sb + 1 < P_LL));
        else
            st = fa_f || fb_f;
        st  = st && id_valid && !redirect;
        fwa = (p_fe(i) != 0 && fa_f) ? sa + 1 : 0;
        fwb = (p_fe(i) != 0 && fb_f) ? sb + 1 : 0;
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input int rd, input bit wr, input bit ld, input bit red);
        id_valid  = v;
        id_rs     = 5'(rs);
        id_rt     = 5'(rt);
        id_use_rs = urs;
        id_use_rt = urt;
        id_rd     = 5'(rd);
        id_wr     = wr;
        id_load   = ld;
        redirect  = red;
    endtask

    task automatic step();
        bit st;
        int fwa, fwb;
        #1;
        for (int i = 0; i < NI; i++) begin
            model_eval(i, st, fwa, fwb);
            check($sformatf("stall[%0d]", i), o_stall[i], st);
            check($sformatf("flush[%0d]", i), o_flush[i], redirect);
            check($sformatf("fwd_a[%0d]", i), o_fa[i], exp_fa[i]);
            check($sformatf("fwd_b[%0d]", i), o_fb[i], exp_fb[i]);
            check($sformatf("stall_cnt[%0d]", i), o_cnt[i], exp_cnt[i]);
        end
    endtask

    task automatic adv();
        bit st, issue;
        int fwa, fwb;
        for (int i = 0; i < NI; i++) begin
            model_eval(i, st, fwa, fwb);
            if (reset) begin
                for (int k = 0; k < HD; k++) h_v[i][k] = 1'b0;
                exp_fa[i]  = 0;
                exp_fb[i]  = 0;
                exp_cnt[i] = 0;
            end else begin
                issue      = id_valid && !st && !redirect;
                exp_fa[i]  = issue ? fwa : 0;
                exp_fb[i]  = issue ? fwb : 0;
                if (st && exp_cnt[i] < 65535) exp_cnt[i]++;
                if (issue) begin
                    for (int k = HD-1; k > 0; k--) begin
                        h_v[i][k]   = h_v[i][k-1];
                        h_cyc[i][k] = h_cyc[i][k-1];
                        h_rd[i][k]  = h_rd[i][k-1];
                        h_wr[i][k]  = h_wr[i][k-1];
                        h_ld[i][k]  = h_ld[i][k-1];
                    end
                    h_v[i][0]   = 1'b1;
                    h_cyc[i][0] = cyc + 1;
                    h_rd[i][0]  = int'(id_rd);
                    h_wr[i][0]  = id_wr;
                    h_ld[i][0]  = id_load;
                end
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < HD; k++) h_v[i][k] = 1'b0;
            exp_fa[i] = 0; exp_fb[i] = 0; exp_cnt[i] = 0;
        end
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clock);
        reset = 1'b0;

        step();
        check("rst_stall", o_stall[0], 0);
        check("rst_fwd_a", o_fa[0], 0);
        check("rst_cnt", o_cnt[0], 0);
        adv();

        // lw r8 ; add r9,r8,r1
        drive(1, 0, 0, 0, 0, 8, 1, 1, 0); step(); adv();
        drive(1, 8, 1, 1, 1, 9, 1, 0, 0); step();
        check("lu_stall_1", o_stall[0], 1); adv();
        step();
        check("lu_stall_2", o_stall[0], 0); adv();
        idle(); step();
        check("lu_fwd_a", o_fa[0], 2);
        check("lu_fwd_b", o_fb[0], 0); adv();

        // add r3 ; sub r4,r3,r3
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0); step(); adv();
        drive(1, 3, 3, 1, 1, 4, 1, 0, 0); step();
        check("alu_nostall", o_stall[0], 0); adv();
        idle(); step();
        check("alu_fwd_a", o_fa[0], 1);
        check("alu_fwd_b", o_fb[0], 1); adv();

        // two writers of r5, youngest wins; rt=r0 never forwards
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); step(); adv();
        step(); adv();
        drive(1, 5, 0, 1, 1, 6, 1, 0, 0); step();
        check("yng_nostall", o_stall[0], 0); adv();
        idle(); step();
        check("yng_fwd_a", o_fa[0], 1);
        check("yng_fwd_b", o_fb[0], 0); adv();

        // writer of r0 followed by a reader of r0
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0); step(); adv();
        drive(1, 0, 0, 1, 1, 7, 1, 0, 0); step();
        check("r0_nostall0", o_stall[0], 0);
        check("r0_nostall1", o_stall[1], 0); adv();
        idle(); step();
        check("r0_fwd_a", o_fa[0], 0); adv();

        // redirect while a load-use hazard is pending
        drive(1, 0, 0, 0, 0, 8, 1, 1, 0); step(); adv();
        drive(1, 8, 0, 1, 0, 12, 1, 0, 1); step();
        check("rd_flush", o_flush[0], 1);
        check("rd_stall", o_stall[0], 0); adv();
        drive(1, 12, 0, 1, 0, 13, 1, 0, 0); step();
        check("rd_fwd_a", o_fa[0], 0);
        check("rd_bub_stall", o_stall[0], 0); adv();
        idle(); step();
        check("rd_bub_fwd", o_fa[0], 0); adv();

        repeat (8) begin idle(); step(); adv(); end

        // no-forwarding configuration with four stages
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0); step(); adv();
        drive(1, 2, 0, 1, 0, 20, 0, 0, 0);
        stall_run = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            seen = o_stall[1];
            adv();
            if (!seen) break;
            stall_run++;
        end
        check("nf_stall_run", stall_run, 3);
        idle(); step();
        check("nf_fwd_a", o_fa[1], 0); adv();

        // reset in the middle of a stall
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0); step(); adv();
        drive(1, 2, 0, 1, 0, 20, 0, 0, 0); step();
        check("rs_pre", o_stall[1], 1); adv();
        reset = 1'b1; step(); adv();
        reset = 1'b0; step();
        check("rs_abandon", o_stall[1], 0);
        check("rs_cnt", o_cnt[1], 0); adv();

        for (int t = 0; t < 2000; t++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
            step();
            adv();
        end
        reset = 1'b0;

        // add r1,r1,r1 repeatedly keeps the 8-stage no-forward config stalling
        drive(1, 1, 0, 1, 0, 1, 1, 0, 0);
        for (int t = 0; t < 75500; t++) begin
            step();
            adv();
        end
        step();
        check("sat_cnt", o_cnt[2], 16'hFFFF); adv();
        reset = 1'b1; step(); adv();
        reset = 1'b0; idle(); step();
        check("sat_rst_cnt", o_cnt[2], 0); adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
